pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard unit for a five-stage in-order pipeline. It resolves:
//   - data hazards by forwarding Memory/Writeback results into Execute,
//   - load-use hazards by a one-cycle Fetch/Decode stall plus Execute bubble,
//   - control hazards by flushing Decode and Execute on a taken branch/jump,
//   - data-memory wait states by freezing F/D/E/M and bubbling Writeback.
// It also raises a sticky flag when one memory wait lasts MEM_TIMEOUT
// cycles, and keeps a saturating count of cycles with Fetch stalled.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   rs1_d, rs2_d                  Decode source registers
//   rs1_e, rs2_e, rd_e            Execute source/destination registers
//   result_src_e                  Execute result select (2'b01 = load)
//   pc_src_e                      branch taken / jump resolved in Execute
//   rd_m, rd_w                    Memory / Writeback destination registers
//   reg_write_m, reg_write_w      Memory / Writeback register-write enables
//   mem_req_m, mem_ready          data-memory request / completion
//   stall_f/d/e/m                 hold the pipeline register of that stage
//   flush_d/e/w                   insert a bubble into that stage
//   forward_a_e, forward_b_e      operand select: 00 RF, 01 WB, 10 MEM
//   mem_timeout                   sticky wait-timeout flag
//   stall_cycles                  saturating count of Fetch-stall cycles
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rs1_e,
  input  logic [4:0]  rs2_e,
  input  logic [4:0]  rd_e,
  input  logic [1:0]  result_src_e,
  input  logic        pc_src_e,
  input  logic [4:0]  rd_m,
  input  logic [4:0]  rd_w,
  input  logic        reg_write_m,
  input  logic        reg_write_w,
  input  logic        mem_req_m,
  input  logic        mem_ready,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_w,
  output logic [1:0]  forward_a_e,
  output logic [1:0]  forward_b_e,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles
);

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic        mem_stall_s;
  logic        lw_stall_s;

  // Memory stage wins over Writeback because it holds the younger result.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rdm, input logic rwm,
                                         input logic [4:0] rdw, input logic rww);
    logic [1:0] sel;
    if (rwm && (rdm != 5'd0) && (rdm == rs)) begin
      sel = 2'b10;
    end else if (rww && (rdw != 5'd0) && (rdw == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Forwarding selects: purely combinational, independent of FSM and reset.
  always_comb begin
    forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
    forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
  end

  // Hazard detection, FSM next state and wait counter.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_stall_s = 1'b0;
    lw_stall_s  = (result_src_e == 2'b01) && (rd_e != 5'd0) &&
                  ((rd_e == rs1_d) || (rd_e == rs2_d));
    case (state_q)
      IDLE: begin
        wait_cnt_d  = 8'd0;
        mem_stall_s = mem_req_m && !mem_ready;
        if (mem_req_m && !mem_ready) begin
          state_d = MEM_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      MEM_WAIT: begin
        mem_stall_s = !mem_ready;
        if (mem_ready) begin
          state_d = IDLE;
        end else begin
          state_d = MEM_WAIT;
          if (wait_cnt_q < TIMEOUT_C) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end else begin
            wait_cnt_d = wait_cnt_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stall/flush priority: memory wait, then redirect, then load-use.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!rst_n) begin
      stall_f = 1'b0;
    end else if (mem_stall_s) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_stall_s) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      stall_f = 1'b0;
    end
  end

  // Sticky timeout and saturating stall counter next state.
  always_comb begin
    mem_timeout_d = mem_timeout_q | (wait_cnt_d == TIMEOUT_C);
    if (stall_f && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      wait_cnt_q     <= 8'd0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;

endmodule
